debug_trace_buffer: RTL and testbench

- Parametrised trace-capture block that records per-lane debug records (commit/stage snapshots) from CHANNEL_NUM lanes into a circular buffer.
- Supports arm/trigger/post-trigger capture and a valid/ready readout port. The captured window can be drained after a hang or mismatch.
- Sits beside the debug register aggregation and takes lane records from CommitStage or any stage debug output. Its readout feeds the host debug path.

---
 rtl/debug_trace_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_debug_trace_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
//   Trace-capture block that records per-lane debug records from CHANNEL_NUM
//   lanes into a circular buffer. Capture is armed and then triggered. After the
//   trigger a programmable number of records is still taken, and then the window
//   freezes. The frozen window drains oldest-first through a valid/ready port.
//
//   Optional build macro: DEBUG_TRACE_TIMESTAMP_EN
//     When it is defined, a free-running 32-bit cycle counter stamps every stored
//     entry as {timestamp, record}, and rdData widens to RECORD_WIDTH+32.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   arm        start capture (honoured only in IDLE)
//   clear      abort to IDLE and flush (highest priority)
//   trigger    trigger pulse (honoured only in ARMED)
//   postCount  records to capture after the trigger, sampled on an accepted arm
//   chValid    per-lane record valid
//   chRecord   lane records, lane i at [i*RECORD_WIDTH +: RECORD_WIDTH]
//   rdReady    readout consumer ready
//   rdValid    readout record available (FROZEN and not empty)
//   rdData     oldest held entry
//   state      0 IDLE, 1 ARMED, 2 POST, 3 FROZEN
//   fillCount  number of valid entries held
//   overflowed older records were overwritten during capture
//   triggered  a trigger was accepted
module debug_trace_buffer #(
    parameter int CHANNEL_NUM  = 4,
    parameter int RECORD_WIDTH = 64,
    parameter int DEPTH        = 256,
    parameter int CNT_WIDTH    = $clog2(DEPTH) + 1,
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    localparam int OUT_WIDTH   = RECORD_WIDTH + 32
`else
    localparam int OUT_WIDTH   = RECORD_WIDTH
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                arm,
    input  logic                                clear,
    input  logic                                trigger,
    input  logic [CNT_WIDTH-1:0]                postCount,
    input  logic [CHANNEL_NUM-1:0]              chValid,
    input  logic [CHANNEL_NUM*RECORD_WIDTH-1:0] chRecord,
    input  logic                                rdReady,
    output logic                                rdValid,
    output logic [OUT_WIDTH-1:0]                rdData,
    output logic [1:0]                          state,
    output logic [CNT_WIDTH-1:0]                fillCount,
    output logic                                overflowed,
    output logic                                triggered
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_POST   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    localparam logic [CNT_WIDTH:0] DEPTH_X = (CNT_WIDTH+1)'(DEPTH);

    // Clamp a count to the buffer depth.
    function automatic logic [CNT_WIDTH-1:0] satDepth(input logic [CNT_WIDTH:0] v);
        if (v > DEPTH_X)
            return DEPTH_X[CNT_WIDTH-1:0];
        else
            return v[CNT_WIDTH-1:0];
    endfunction

    logic [OUT_WIDTH-1:0]   mem [DEPTH];
    logic [OUT_WIDTH-1:0]   laneData [CHANNEL_NUM];
    logic [PTR_W-1:0]       laneOff [CHANNEL_NUM];
    logic [PTR_W-1:0]       wrPtr;
    logic [PTR_W-1:0]       rdPtr;
    logic [PTR_W-1:0]       wrPtrNext;
    logic [CNT_WIDTH-1:0]   postRemain;
    logic [CNT_WIDTH-1:0]   nCap;
    logic [CHANNEL_NUM-1:0] capMask;
    logic [CNT_WIDTH:0]     fillSum;
    logic                   capEn;
    logic                   limitOn;
    logic                   pop;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [31:0] tsCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tsCount <= '0;
        else
            tsCount <= tsCount + 32'd1;
    end

    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++)
            laneData[i] = {tsCount, chRecord[i*RECORD_WIDTH +: RECORD_WIDTH]};
    end
`else
    always_comb begin
        for (int i = 0; i < CHANNEL_NUM; i++)
            laneData[i] = chRecord[i*RECORD_WIDTH +: RECORD_WIDTH];
    end
`endif

    // Lane compaction: each captured lane gets the rank among captured lanes
    // below it, so valid lanes land in consecutive entries, lowest lane first.
    // In POST only the lowest postRemain valid lanes are taken.
    always_comb begin
        capEn   = (state == ST_ARMED) || (state == ST_POST);
        limitOn = (state == ST_POST);
        nCap    = '0;
        capMask = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            laneOff[i] = nCap[PTR_W-1:0];
            if (capEn && chValid[i] && (!limitOn || (nCap < postRemain))) begin
                capMask[i] = 1'b1;
                nCap       = nCap + CNT_WIDTH'(1);
            end
        end
    end

    // nCap can equal DEPTH only when CHANNEL_NUM == DEPTH; its low bits are
    // then zero, and that still wraps the pointer correctly.
    assign wrPtrNext = wrPtr + nCap[PTR_W-1:0];
    assign fillSum   = {1'b0, fillCount} + {1'b0, nCap};
    assign rdValid   = (state == ST_FROZEN) && (fillCount != '0);
    assign rdData    = mem[rdPtr];
    assign pop       = rdValid && rdReady;

    // Storage is data only; it is never reset, and fillCount says what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (capMask[i] && !clear)
                mem[wrPtr + laneOff[i]] <= laneData[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fillCount  <= '0;
            postRemain <= '0;
            overflowed <= 1'b0;
            triggered  <= 1'b0;
        end else if (clear) begin
            state      <= ST_IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fillCount  <= '0;
            postRemain <= '0;
            overflowed <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        wrPtr      <= '0;
                        rdPtr      <= '0;
                        fillCount  <= '0;
                        overflowed <= 1'b0;
                        triggered  <= 1'b0;
                        postRemain <= satDepth({1'b0, postCount});
                        state      <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_POST: begin
                    wrPtr     <= wrPtrNext;
                    fillCount <= satDepth(fillSum);
                    // After a wrap, the oldest surviving entry is the next one
                    // that would be overwritten.
                    if (fillSum > DEPTH_X) begin
                        rdPtr      <= wrPtrNext;
                        overflowed <= 1'b1;
                    end
                    if (state == ST_ARMED) begin
                        if (trigger) begin
                            triggered <= 1'b1;
                            state     <= (postRemain == '0) ? ST_FROZEN : ST_POST;
                        end
                    end else begin
                        postRemain <= postRemain - nCap;
                        if (postRemain == nCap)
                            state <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (pop) begin
                        rdPtr     <= rdPtr + PTR_W'(1);
                        fillCount <= fillCount - CNT_WIDTH'(1);
                        if (fillCount == CNT_WIDTH'(1))
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Testbench for debug_trace_buffer (CHANNEL_NUM=4, RECORD_WIDTH=16, DEPTH=8).
module tb_debug_trace_buffer;

    localparam int CH = 4;
    localparam int RW = 16;
    localparam int D  = 8;
    localparam int CW = 4;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    localparam int OW = RW + 32;
`else
    localparam int OW = RW;
`endif

    logic            clk;
    logic            rst;
    logic            arm;
    logic            clear;
    logic            trigger;
    logic [CW-1:0]   postCount;
    logic [CH-1:0]   chValid;
    logic [CH*RW-1:0] chRecord;
    logic            rdReady;
    logic            rdValid;
    logic [OW-1:0]   rdData;
    logic [1:0]      state;
    logic [CW-1:0]   fillCount;
    logic            overflowed;
    logic            triggered;

    debug_trace_buffer #(
        .CHANNEL_NUM(CH), .RECORD_WIDTH(RW), .DEPTH(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .trigger(trigger),
        .postCount(postCount), .chValid(chValid), .chRecord(chRecord),
        .rdReady(rdReady), .rdValid(rdValid), .rdData(rdData), .state(state),
        .fillCount(fillCount), .overflowed(overflowed), .triggered(triggered)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index since reset release; equals the value the timestamp counter holds.
    logic [31:0] cyc;
    always @(posedge clk) cyc <= rst ? cyc + 32'd1 : 32'd0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int c, input int t, input int pc,
                         input int v, input logic [63:0] rec, input int rr);
        arm       = (a != 0);
        clear     = (c != 0);
        trigger   = (t != 0);
        postCount = CW'(pc);
        chValid   = CH'(v);
        chRecord  = rec;
        rdReady   = (rr != 0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 64'd0, 0);
    endtask

    task automatic doReset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- reference model: a plain queue of entries ----------------
    logic [OW-1:0] mq[$];
    int mSt;
    int mPost;
    bit mOvf;
    bit mTrg;

    function automatic logic [OW-1:0] mkEntry(input logic [RW-1:0] r);
`ifdef DEBUG_TRACE_TIMESTAMP_EN
        return {cyc, r};
`else
        return r;
`endif
    endfunction

    task automatic modelReset();
        mq.delete();
        mSt = 0; mPost = 0; mOvf = 0; mTrg = 0;
    endtask

    task automatic modelPush(input logic [OW-1:0] e);
        mq.push_back(e);
        if (mq.size() > D) begin
            mq.delete(0);
            mOvf = 1;
        end
    endtask

    task automatic modelStep(input bit a, input bit c, input bit t, input int pc,
                             input logic [CH-1:0] v, input logic [CH*RW-1:0] rec, input bit rr);
        if (c) begin
            modelReset();
        end else begin
            case (mSt)
                0: if (a) begin
                    mq.delete();
                    mOvf = 0; mTrg = 0;
                    mPost = (pc > D) ? D : pc;
                    mSt = 1;
                end
                1: begin
                    for (int i = 0; i < CH; i++)
                        if (v[i]) modelPush(mkEntry(rec[i*RW +: RW]));
                    if (t) begin
                        mTrg = 1;
                        mSt = (mPost == 0) ? 3 : 2;
                    end
                end
                2: begin
                    for (int i = 0; i < CH; i++)
                        if (v[i] && mPost > 0) begin
                            modelPush(mkEntry(rec[i*RW +: RW]));
                            mPost--;
                        end
                    if (mPost == 0) mSt = 3;
                end
                default: if (mq.size() > 0 && rr) begin
                    mq.delete(0);
                    if (mq.size() == 0) mSt = 0;
                end
            endcase
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          arm;
        bit          trg;
        logic [3:0]  pc;
        logic [3:0]  v;
        logic [15:0] rec;
        bit          rr;
        logic [1:0]  st;
        logic [3:0]  fill;
        bit          rv;
        logic [15:0] data;
        bit          trd;
        bit          ovf;
    } vec_t;

    function automatic vec_t mk(input int a, input int t, input int pc, input int v,
                                input int rec, input int rr, input int st, input int fill,
                                input int rv, input int data, input int trd, input int ovf);
        vec_t r;
        r.arm = (a != 0);  r.trg = (t != 0);  r.pc = 4'(pc);  r.v = 4'(v);
        r.rec = 16'(rec);  r.rr = (rr != 0);  r.st = 2'(st);  r.fill = 4'(fill);
        r.rv = (rv != 0);  r.data = 16'(data); r.trd = (trd != 0); r.ovf = (ovf != 0);
        return r;
    endfunction

    vec_t tbl[13];

    initial begin
        rst = 1'b0;
        idle();

        //          arm trg pc v rec   rr  st fill rv data trd ovf
        tbl[0]  = mk(0, 0, 0, 0, 0,    0,  0, 0, 0, 0,    0, 0);
        tbl[1]  = mk(1, 0, 2, 0, 0,    0,  0, 0, 0, 0,    0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 'hA,  0,  1, 0, 0, 0,    0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 'hB,  0,  1, 1, 0, 0,    0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 'hC,  0,  1, 2, 0, 0,    0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 'hD,  0,  2, 3, 0, 0,    1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 'hE,  0,  2, 4, 0, 0,    1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,    1,  3, 5, 1, 'hA,  1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0,    1,  3, 4, 1, 'hB,  1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,    1,  3, 3, 1, 'hC,  1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0,    1,  3, 2, 1, 'hD,  1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0,    1,  3, 1, 1, 'hE,  1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0,    0,  0, 0, 0, 0,    1, 0);

        doReset();

        for (int i = 0; i < 13; i++) begin
            drive(int'(tbl[i].arm), 0, int'(tbl[i].trg), int'(tbl[i].pc), int'(tbl[i].v),
                  {48'd0, tbl[i].rec}, int'(tbl[i].rr));
            chk($sformatf("tbl%0d state", i), 64'(state), 64'(tbl[i].st));
            chk($sformatf("tbl%0d fill", i), 64'(fillCount), 64'(tbl[i].fill));
            chk($sformatf("tbl%0d rdValid", i), 64'(rdValid), 64'(tbl[i].rv));
            chk($sformatf("tbl%0d triggered", i), 64'(triggered), 64'(tbl[i].trd));
            chk($sformatf("tbl%0d overflowed", i), 64'(overflowed), 64'(tbl[i].ovf));
            if (tbl[i].rv)
                chk($sformatf("tbl%0d rdData", i), 64'(rdData[RW-1:0]), 64'(tbl[i].data));
            tick();
        end

        // Trigger outside ARMED, and arm together with clear, are both ignored.
        drive(0, 0, 1, 0, 1, 64'd7, 0);
        tick();
        drive(1, 1, 0, 3, 0, 64'd0, 0);
        tick();
        idle();
        chk("idle trigger/arm+clear state", 64'(state), 64'd0);
        chk("idle trigger ignored", 64'(triggered), 64'd0);

        // Compaction: lanes 0,1,3 valid -> entries 1,2,4.
        drive(1, 0, 0, 0, 0, 64'd0, 0);
        tick();
        drive(0, 0, 1, 0, 4'b1011, {16'd4, 16'd3, 16'd2, 16'd1}, 0);
        tick();
        idle();
        chk("compact state", 64'(state), 64'd3);
        chk("compact fill", 64'(fillCount), 64'd3);
        rdReady = 1'b1;
        chk("compact rd0", 64'(rdData[RW-1:0]), 64'd1);
        tick();
        chk("compact rd1", 64'(rdData[RW-1:0]), 64'd2);
        tick();
        chk("compact rd2", 64'(rdData[RW-1:0]), 64'd4);
        tick();
        idle();
        chk("compact drained state", 64'(state), 64'd0);

        // Overflow: ten records into eight entries, trigger on an empty cycle.
        drive(1, 0, 0, 0, 0, 64'd0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 1, 64'(k), 0);
            tick();
        end
        drive(0, 0, 1, 0, 0, 64'd0, 0);
        tick();
        idle();
        chk("ovf state", 64'(state), 64'd3);
        chk("ovf flag", 64'(overflowed), 64'd1);
        chk("ovf fill", 64'(fillCount), 64'd8);
        rdReady = 1'b1;
        for (int k = 2; k < 10; k++) begin
            chk($sformatf("ovf rd%0d", k), 64'(rdData[RW-1:0]), 64'(k));
            tick();
        end
        idle();
        chk("ovf drained state", 64'(state), 64'd0);
        chk("ovf flag held", 64'(overflowed), 64'd1);

        // POST limit: postCount=3, four lanes offered after an empty trigger cycle.
        drive(1, 0, 0, 3, 0, 64'd0, 0);
        tick();
        drive(0, 0, 1, 0, 0, 64'd0, 0);
        tick();
        drive(0, 0, 0, 0, 4'b1111, {16'd8, 16'd7, 16'd6, 16'd5}, 0);
        chk("post state", 64'(state), 64'd2);
        tick();
        idle();
        chk("post frozen", 64'(state), 64'd3);
        chk("post fill", 64'(fillCount), 64'd3);
        rdReady = 1'b1;
        for (int k = 5; k < 8; k++) begin
            chk($sformatf("post rd%0d", k), 64'(rdData[RW-1:0]), 64'(k));
            tick();
        end
        idle();
        chk("post drained state", 64'(state), 64'd0);

        // Clear in FROZEN beats a same-cycle pop.
        drive(1, 0, 0, 0, 0, 64'd0, 0);
        tick();
        drive(0, 0, 1, 0, 4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 0);
        tick();
        idle();
        chk("clr pre fill", 64'(fillCount), 64'd4);
        chk("clr pre rdValid", 64'(rdValid), 64'd1);
        drive(0, 1, 0, 0, 0, 64'd0, 1);
        tick();
        idle();
        chk("clr state", 64'(state), 64'd0);
        chk("clr fill", 64'(fillCount), 64'd0);
        chk("clr rdValid", 64'(rdValid), 64'd0);
        chk("clr triggered", 64'(triggered), 64'd0);

        // Asynchronous reset in the middle of a capture discards everything.
        drive(1, 0, 0, 2, 0, 64'd0, 0);
        tick();
        drive(0, 0, 0, 0, 4'b0011, {32'd0, 16'd9, 16'd8}, 0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("async rst state", 64'(state), 64'd0);
        chk("async rst fill", 64'(fillCount), 64'd0);
        tick();
        rst = 1'b1;
        idle();

`ifdef DEBUG_TRACE_TIMESTAMP_EN
        // Timestamps: arm in cycle 10, records in cycles 12 and 15.
        doReset();
        for (int g = 0; g < 50 && cyc != 32'd10; g++) tick();
        chk("ts reached cycle 10", 64'(cyc), 64'd10);
        drive(1, 0, 0, 0, 0, 64'd0, 0);
        tick();
        idle();
        tick();
        drive(0, 0, 0, 0, 1, 64'h11, 0);
        tick();
        idle();
        tick();
        tick();
        drive(0, 0, 1, 0, 1, 64'h22, 0);
        tick();
        idle();
        chk("ts state", 64'(state), 64'd3);
        rdReady = 1'b1;
        chk("ts first", 64'(rdData[RW +: 32]), 64'd12);
        tick();
        chk("ts second", 64'(rdData[RW +: 32]), 64'd15);
        tick();
        idle();
`endif

        // Randomized run against the queue model.
        doReset();
        modelReset();
        for (int n = 0; n < 800; n++) begin
            bit a, c, t, rr;
            int pc;
            logic [CH-1:0] v;
            logic [CH*RW-1:0] rec;
            a  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 59) == 0);
            t  = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 3) != 0);
            pc = $urandom_range(0, 15);
            v  = CH'($urandom);
            rec = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            drive(int'(a), int'(c), int'(t), pc, int'(v), rec, int'(rr));
            chk("rnd state", 64'(state), 64'(mSt));
            chk("rnd fill", 64'(fillCount), 64'(mq.size()));
            chk("rnd rdValid", 64'(rdValid), 64'((mSt == 3) && (mq.size() > 0)));
            chk("rnd overflowed", 64'(overflowed), 64'(mOvf));
            chk("rnd triggered", 64'(triggered), 64'(mTrg));
            if (mSt == 3 && mq.size() > 0)
                chk("rnd rdData", 64'(rdData), 64'(mq[0]));
            modelStep(a, c, t, pc, v, rec, rr);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
